am2911_seq_core: RTL and testbench
==================================

Name: am2911_seq_core

Overview:
- Microprogram address engine that consumes the next-address control word from the am29811a: source select `s`, stack controls `fe_`/`pup`, counter controls `cntload_`/`cnte_`, and D-source enables `mape_`/`ple_`.
- Integrates an Am2911-style sequencer (uPC, register R, LIFO stack) with a loadable down-counter.
- Drives the microprogram memory address `y`, and returns `ctr_zero` for use as the am29811a `test` input.

Parameters:
- WIDTH, 12, address / counter / D bus width
- DEPTH, 4, stack entries (power of two not required)
- SPW, 3, sp_level width; must satisfy 2**SPW > DEPTH

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- s  in  2  address source: 00 uPC, 01 R, 10 stack top, 11 D
- fe_  in  1  file enable, active low
- pup  in  1  1 = push, 0 = pop (valid when fe_=0)
- cntload_  in  1  load counter from D, active low
- cnte_  in  1  counter decrement enable, active low
- mape_  in  1  select d_map as D, active low
- ple_  in  1  select d_pl as D, active low
- d_pl  in  WIDTH  pipeline-register branch field
- d_map  in  WIDTH  mapping PROM output
- d_vec  in  WIDTH  vector source (both enables high)
- re_  in  1  load R from D, active low
- zero_  in  1  force y to 0, active low
- cin  in  1  uPC increment carry
- y  out  WIDTH  next microaddress (combinational)
- ctr_zero  out  1  counter == 0
- sp_level  out  SPW  stack occupancy 0..DEPTH
- stk_full  out  1  sp_level == DEPTH
- stk_empty  out  1  sp_level == 0
- stk_err  out  1  sticky push-on-full / pop-on-empty

Behaviour:
- D mux (combinational):
  - ple_=0 selects d_pl, including when both ple_ and mape_ are 0 (illegal combination, d_pl has priority).
  - Otherwise mape_=0 selects d_map.
  - Both high selects d_vec.
- y (combinational):
  - zero_=0 forces y = 0.
  - Otherwise y = mux(s): uPC, R, top, D.
  - top = file[sp_level-1]; top = 0 when the stack is empty.
- All state updates occur on the rising clk edge.
- uPC <= y + cin, modulo 2**WIDTH; all-ones + 1 wraps to 0.
- R <= D when re_=0.
- Stack (state used is the value before the clock edge):
  - fe_=1: no change.
  - fe_=0, pup=1: if not full, file[sp] <= uPC (old uPC, i.e. the return address) and sp++. If full, no write, sp unchanged, stk_err <= 1.
  - fe_=0, pup=0: if not empty, sp--. If empty, sp unchanged, stk_err <= 1.
  - Same-cycle s=10 with push or pop: y uses the pre-edge top.
- Counter (WIDTH bits):
  - cntload_=0 loads D; load has priority over cnte_.
  - Else cnte_=0 decrements, wrapping 0 -> all-ones.
  - ctr_zero is combinational from the counter register.
- Reset (rst=1 at an edge):
  - uPC = 0, R = 0, counter = 0, sp = 0, stk_err = 0; file contents are don't-care.
  - Reset overrides all simultaneous loads, pushes and pops.
  - After reset: ctr_zero = 1, stk_empty = 1, and y = 0 when s=00 and cin is not applied.
- stk_err clears only on rst.
- No latency beyond one clock for any state element; y has zero-cycle latency from its inputs.

Optional Feature:
- Macro: AM2911_SEQ_OR_INPUTS_EN
- Defined:
  - Adds input or_in [3:0].
  - y = (mux result) | {0, or_in} before the zero_ force; zero_=0 still yields 0.
  - uPC increments from the ORed y.
  - Used for multiway branches.
- Undefined:
  - No or_in port.
  - y is the plain mux result.

Test Plan:
1. Reset, then JZ sequence: rst=1, one clk -> y=0 (s=00), ctr_zero=1, sp_level=0, stk_err=0. Release; s=00, cin=1, 3 clks -> y=3.
2. CJS / CRTN:
   - Prepare: uPC=0x010, s=11, fe_=0, pup=1, ple_=0, d_pl=0x200, clk -> y=0x200, sp_level=1, file[0]=0x010.
   - Return: s=10, fe_=0, pup=0 -> y=0x010; after clk sp_level=0 and uPC=0x011.
3. LDCT / RFCT loop:
   - Load: cntload_=0 with D=3.
   - Per iteration: cnte_=0 each clk -> ctr_zero is 0 for 2 more decrements.
   - After 3 decrements ctr_zero=1.
   - A 4th decrement wraps the counter to 0xFFF.
4. JMAP / vector: mape_=0, ple_=1, d_map=0x0A5, s=11 -> y=0x0A5. Both enables high with d_vec=0x3C0 -> y=0x3C0. Both low -> y=d_pl.
5. Stack bounds:
   - DEPTH+1 pushes -> stk_full=1, sp_level=4, stk_err=1; the 5th value is not stored.
   - Pop 5 times -> sp_level=0, stk_empty=1, stk_err stays 1.
   - rst clears stk_err.
6. zero_ and R:
   - re_=0 with D=0x155, clk -> R=0x155; then s=01 gives y=0x155.
   - zero_=0 -> y=0, uPC <= cin.
   - With the macro defined: or_in=4'b0011, D=0x100 -> y=0x103.

Source files
------------

// File: rtl/am2911_seq_core.sv
// am2911_seq_core: Am2911-style microaddress sequencer (uPC, R, LIFO) with loadable down-counter.
// Optional multiway-branch OR inputs are enabled by defining AM2911_SEQ_OR_INPUTS_EN.
module am2911_seq_core #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int SPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
`ifdef AM2911_SEQ_OR_INPUTS_EN
  input  logic [3:0]       or_in,
`endif
  input  logic [1:0]       s,
  input  logic             fe_,
  input  logic             pup,
  input  logic             cntload_,
  input  logic             cnte_,
  input  logic             mape_,
  input  logic             ple_,
  input  logic [WIDTH-1:0] d_pl,
  input  logic [WIDTH-1:0] d_map,
  input  logic [WIDTH-1:0] d_vec,
  input  logic             re_,
  input  logic             zero_,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             ctr_zero,
  output logic [SPW-1:0]   sp_level,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);
  logic [WIDTH-1:0] upc_q, upc_d, r_q, r_d, ctr_q, ctr_d, d, top, mux;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d, push, pop;
  // File is sized to the full pointer range so sp indexes it without truncation.
  logic [WIDTH-1:0] file_q [0:2**SPW-1];
  logic [WIDTH-1:0] file_d [0:2**SPW-1];
  assign stk_full  = sp_q == SPW'(DEPTH);
  assign stk_empty = sp_q == '0;
  assign sp_level  = sp_q;
  assign stk_err   = err_q;
  assign ctr_zero  = ctr_q == '0;
  always_comb begin
    d    = !ple_ ? d_pl : (!mape_ ? d_map : d_vec);
    top  = stk_empty ? '0 : file_q[sp_q - SPW'(1)];
    mux  = s == 2'b00 ? upc_q : s == 2'b01 ? r_q : s == 2'b10 ? top : d;
`ifdef AM2911_SEQ_OR_INPUTS_EN
    mux  = mux | {{(WIDTH-4){1'b0}}, or_in};
`endif
    y    = zero_ ? mux : '0;
    upc_d = y + WIDTH'(cin);
    r_d   = !re_ ? d : r_q;
    ctr_d = !cntload_ ? d : (!cnte_ ? ctr_q - WIDTH'(1) : ctr_q);
    push  = !fe_ && pup;
    pop   = !fe_ && !pup;
    sp_d  = push ? (stk_full ? sp_q : sp_q + SPW'(1)) :
            pop  ? (stk_empty ? sp_q : sp_q - SPW'(1)) : sp_q;
    err_d = err_q | (push & stk_full) | (pop & stk_empty);
    file_d = file_q;
    if (push && !stk_full) file_d[sp_q] = upc_q;
  end
  always_ff @(posedge clk) begin
    file_q <= file_d;
    if (rst) begin
      upc_q <= '0;
      r_q   <= '0;
      ctr_q <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      upc_q <= upc_d;
      r_q   <= r_d;
      ctr_q <= ctr_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_am2911_seq_core.sv
// tb_am2911_seq_core: directed and randomized checks against a queue-based reference model.
module tb_am2911_seq_core;
  logic clk = 0, rst = 1;
  logic [1:0] s;
  logic fe_, pup, cntload_, cnte_, mape_, ple_, re_, zero_, cin;
  logic [11:0] d_pl, d_map, d_vec, y;
  logic [3:0] or_in;
  logic ctr_zero, stk_full, stk_empty, stk_err;
  logic [2:0] sp_level;
  int pass_cnt = 0, total = 0;
  logic [11:0] m_upc, m_r, m_ctr;
  logic m_err;
  logic [11:0] stk[$];

  always #5 clk = ~clk;

  am2911_seq_core dut (
    .clk(clk), .rst(rst),
`ifdef AM2911_SEQ_OR_INPUTS_EN
    .or_in(or_in),
`endif
    .s(s), .fe_(fe_), .pup(pup), .cntload_(cntload_), .cnte_(cnte_),
    .mape_(mape_), .ple_(ple_), .d_pl(d_pl), .d_map(d_map), .d_vec(d_vec),
    .re_(re_), .zero_(zero_), .cin(cin), .y(y), .ctr_zero(ctr_zero),
    .sp_level(sp_level), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  function automatic logic [11:0] model_d();
    return !ple_ ? d_pl : !mape_ ? d_map : d_vec;
  endfunction

  function automatic logic [11:0] model_y();
    logic [11:0] v;
    case (s)
      2'd0: v = m_upc;
      2'd1: v = m_r;
      2'd2: v = stk.size() == 0 ? 12'h000 : stk[stk.size()-1];
      default: v = model_d();
    endcase
`ifdef AM2911_SEQ_OR_INPUTS_EN
    v = v | {8'h00, or_in};
`endif
    return zero_ ? v : 12'h000;
  endfunction

  task automatic tick();
    logic [11:0] ey, dd;
    ey = model_y();
    dd = model_d();
    @(posedge clk);
    if (rst) begin
      m_upc = 0; m_r = 0; m_ctr = 0; m_err = 0; stk.delete();
    end else begin
      if (!fe_ && pup) begin
        if (stk.size() == 4) m_err = 1; else stk.push_back(m_upc);
      end else if (!fe_) begin
        if (stk.size() == 0) m_err = 1; else void'(stk.pop_back());
      end
      m_upc = ey + {11'b0, cin};
      if (!re_) m_r = dd;
      if (!cntload_) m_ctr = dd; else if (!cnte_) m_ctr = m_ctr - 12'd1;
    end
    #1;
  endtask

  task automatic idle();
    s = 0; fe_ = 1; pup = 0; cntload_ = 1; cnte_ = 1; mape_ = 1; ple_ = 1;
    re_ = 1; zero_ = 1; cin = 0; d_pl = 0; d_map = 0; d_vec = 0; or_in = 0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; fe_ = 0; pup = 1; cntload_ = 0; ple_ = 0; d_pl = 12'h7FF; re_ = 0; cin = 1;
    tick();
    rst = 0; idle();
    total++; if (y !== 12'h000) $display("FAIL reset_y got %h exp 000", y); else pass_cnt++;
    total++; if (ctr_zero !== 1'b1) $display("FAIL reset_ctr_zero got %b exp 1", ctr_zero); else pass_cnt++;
    total++; if (sp_level !== 3'd0 || stk_empty !== 1'b1) $display("FAIL reset_sp got %0d/%b exp 0/1", sp_level, stk_empty); else pass_cnt++;
    total++; if (stk_err !== 1'b0) $display("FAIL reset_err got %b exp 0", stk_err); else pass_cnt++;
    cin = 1;
    repeat (3) tick();
    cin = 0; #1;
    total++; if (y !== 12'h003) $display("FAIL jz_count got %h exp 003", y); else pass_cnt++;
  endtask

  task automatic test_call_return();
    idle();
    s = 3; ple_ = 0; d_pl = 12'h00F; cin = 1;
    tick();
    fe_ = 0; pup = 1; d_pl = 12'h200; #1;
    total++; if (y !== 12'h200) $display("FAIL cjs_y got %h exp 200", y); else pass_cnt++;
    tick();
    total++; if (sp_level !== 3'd1) $display("FAIL cjs_sp got %0d exp 1", sp_level); else pass_cnt++;
    s = 2; pup = 0; ple_ = 1; #1;
    total++; if (y !== 12'h010) $display("FAIL crtn_y got %h exp 010", y); else pass_cnt++;
    tick();
    idle();
    total++; if (sp_level !== 3'd0 || y !== 12'h011) $display("FAIL crtn_state got sp=%0d upc=%h exp sp=0 upc=011", sp_level, y); else pass_cnt++;
  endtask

  task automatic test_counter();
    int n;
    idle();
    cntload_ = 0; cnte_ = 0; ple_ = 0; d_pl = 12'd3;
    tick();
    cntload_ = 1; ple_ = 1; #1;
    total++; if (ctr_zero !== 1'b0) $display("FAIL ldct_zero got %b exp 0", ctr_zero); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (ctr_zero !== (i == 2)) $display("FAIL rfct_dec%0d got %b exp %b", i, ctr_zero, i == 2); else pass_cnt++;
    end
    n = 0;
    do begin tick(); n++; end while (!ctr_zero && n < 5000);
    total++; if (n !== 4096) $display("FAIL ctr_wrap got %0d decs exp 4096", n); else pass_cnt++;
    idle();
  endtask

  task automatic test_dmux();
    idle();
    s = 3; mape_ = 0; d_map = 12'h0A5; d_pl = 12'h123; d_vec = 12'h3C0; #1;
    total++; if (y !== 12'h0A5) $display("FAIL jmap got %h exp 0a5", y); else pass_cnt++;
    mape_ = 1; #1;
    total++; if (y !== 12'h3C0) $display("FAIL vector got %h exp 3c0", y); else pass_cnt++;
    mape_ = 0; ple_ = 0; #1;
    total++; if (y !== 12'h123) $display("FAIL both_low got %h exp 123", y); else pass_cnt++;
    idle();
  endtask

  task automatic test_stack_bounds();
    idle();
    rst = 1; tick(); rst = 0;
    fe_ = 0; pup = 1; cin = 1;
    repeat (5) tick();
    idle();
    total++; if (stk_full !== 1'b1 || sp_level !== 3'd4 || stk_err !== 1'b1) $display("FAIL overflow got full=%b sp=%0d err=%b exp 1/4/1", stk_full, sp_level, stk_err); else pass_cnt++;
    s = 2; fe_ = 0; pup = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (y !== (i < 4 ? 12'(3 - i) : 12'h000)) $display("FAIL pop%0d got %h exp %h", i, y, i < 4 ? 12'(3 - i) : 12'h000); else pass_cnt++;
      tick();
    end
    idle();
    total++; if (sp_level !== 3'd0 || stk_empty !== 1'b1 || stk_err !== 1'b1) $display("FAIL underflow got sp=%0d empty=%b err=%b exp 0/1/1", sp_level, stk_empty, stk_err); else pass_cnt++;
    rst = 1; tick(); rst = 0;
    total++; if (stk_err !== 1'b0) $display("FAIL err_clear got %b exp 0", stk_err); else pass_cnt++;
  endtask

  task automatic test_r_zero();
    idle();
    re_ = 0; ple_ = 0; d_pl = 12'h155;
    tick();
    idle(); s = 1; #1;
    total++; if (y !== 12'h155) $display("FAIL r_load got %h exp 155", y); else pass_cnt++;
    s = 3; d_vec = 12'hABC; zero_ = 0; cin = 1; #1;
    total++; if (y !== 12'h000) $display("FAIL zero_y got %h exp 000", y); else pass_cnt++;
    tick();
    idle();
    total++; if (y !== 12'h001) $display("FAIL zero_upc got %h exp 001", y); else pass_cnt++;
`ifdef AM2911_SEQ_OR_INPUTS_EN
    s = 3; ple_ = 0; d_pl = 12'h100; or_in = 4'b0011; #1;
    total++; if (y !== 12'h103) $display("FAIL or_in got %h exp 103", y); else pass_cnt++;
    zero_ = 0; #1;
    total++; if (y !== 12'h000) $display("FAIL or_zero got %h exp 000", y); else pass_cnt++;
    idle();
`endif
  endtask

  task automatic test_random();
    logic [11:0] ey;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      s = 2'($urandom); fe_ = 1'($urandom); pup = 1'($urandom);
      cntload_ = ($urandom_range(0, 3) != 0); cnte_ = 1'($urandom);
      mape_ = 1'($urandom); ple_ = 1'($urandom); re_ = 1'($urandom);
      zero_ = ($urandom_range(0, 7) != 0); cin = 1'($urandom);
      d_pl = 12'($urandom); d_map = 12'($urandom); d_vec = 12'($urandom);
      or_in = 4'($urandom);
      #1;
      ey = model_y();
      total++; if (y !== ey) $display("FAIL rand_y[%0d] got %h exp %h", i, y, ey); else pass_cnt++;
      tick();
      total++;
      if (sp_level !== 3'(stk.size()) || stk_full !== (stk.size() == 4) || stk_empty !== (stk.size() == 0) ||
          stk_err !== m_err || ctr_zero !== (m_ctr == 0))
        $display("FAIL rand_state[%0d] got sp=%0d full=%b empty=%b err=%b cz=%b exp sp=%0d err=%b cz=%b",
                 i, sp_level, stk_full, stk_empty, stk_err, ctr_zero, stk.size(), m_err, m_ctr == 0);
      else pass_cnt++;
    end
    rst = 0;
    idle();
  endtask

  initial begin
    test_reset();
    test_call_return();
    test_counter();
    test_dmux();
    test_stack_bounds();
    test_r_zero();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
